// File: rtl/slot_mem_arbiter.sv
// slot_mem_arbiter: single-beat arbiter from NUM_CH slot requesters onto one shared memory port
//   clk, reset            : clock, synchronous active-high reset
//   ch_req/ch_we          : per-channel request level and write enable
//   ch_addr/ch_din        : packed per-channel address and write data (channel i at [i*W +: W])
//   ch_ack/ch_rdata       : one-cycle completion pulse to the owner, read data valid with it
//   grant/busy            : one-hot owner of the current transaction, FSM not idle
//   timeout_err           : pulsed with ch_ack when the watchdog aborted the transaction
//   mem_addr/din/we/req   : latched request towards the memory port
//   mem_ready/done/dout   : memory port accept, completion and read data
module slot_mem_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 27,
  parameter int DATA_W   = 8,
  parameter int PRIO_CH0 = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        grant,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  output logic                     mem_we,
  output logic                     mem_req,
  input  logic                     mem_ready,
  input  logic                     mem_done,
  input  logic [DATA_W-1:0]        mem_dout
);
  localparam int IW = $clog2(NUM_CH);
  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IW-1:0] last, win;
  logic [IW:0] sum;
  logic found, prio, done_now;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic sel_we;
  logic [15:0] cnt;
  // Round-robin search from last+1; the index wraps by compare-and-subtract so any NUM_CH works.
  always_comb begin
    win = '0;
    found = 1'b0;
    sum = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      sum = {1'b0, last} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_CH)) sum = sum - (IW+1)'(NUM_CH);
      if (!found && ch_req[sum[IW-1:0]] && !(PRIO_CH0 != 0 && sum == '0)) begin
        found = 1'b1;
        win = sum[IW-1:0];
      end
    end
    prio = PRIO_CH0 != 0 && ch_req[0];
    if (prio) win = '0;
  end
  always_comb begin
    sel_addr = '0;
    sel_din = '0;
    sel_we = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == IW'(i)) begin
        sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
        sel_din = ch_din[i*DATA_W +: DATA_W];
        sel_we = ch_we[i];
      end
    end
  end
  // A completion in ISSUE needs the accept in the same cycle; in WAIT mem_done alone suffices.
  assign done_now = mem_done && (state == WAIT || mem_ready);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= IW'(NUM_CH - 1);
      cnt <= '0;
      ch_ack <= '0;
      ch_rdata <= '0;
      grant <= '0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      mem_we <= 1'b0;
      mem_req <= 1'b0;
    end else begin
      ch_ack <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (|ch_req) begin
          grant <= NUM_CH'(1) << win;
          mem_addr <= sel_addr;
          mem_din <= sel_din;
          mem_we <= sel_we;
          mem_req <= 1'b1;
          busy <= 1'b1;
          cnt <= '0;
          state <= ISSUE;
          if (!prio) last <= win;
        end
        ISSUE, WAIT: begin
          cnt <= cnt + 16'd1;
          if (done_now) begin
            mem_req <= 1'b0;
            ch_ack <= grant;
            if (!mem_we) ch_rdata <= mem_dout;
            state <= RESP;
          end else if (cnt == TMAX) begin
            mem_req <= 1'b0;
            ch_ack <= grant;
            ch_rdata <= '1;
            timeout_err <= 1'b1;
            state <= RESP;
          end else if (state == ISSUE && mem_ready) begin
            mem_req <= 1'b0;
            state <= WAIT;
          end
        end
        default: begin
          grant <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_slot_mem_arbiter.sv
// tb_slot_mem_arbiter: directed self-checking bench for slot_mem_arbiter (4 channels, CPU priority, TIMEOUT=8)
module tb_slot_mem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] ch_req = '0, ch_we = '0, ch_ack, grant;
  logic [4*27-1:0] ch_addr = '0;
  logic [4*8-1:0] ch_din = '0;
  logic [7:0] ch_rdata, mem_din, mem_dout = '0;
  logic [26:0] mem_addr;
  logic busy, timeout_err, mem_we, mem_req, mem_ready = 1'b0, mem_done = 1'b0;
  logic ack_seen;
  int checks = 0, failures = 0;
  logic [3:0] rr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
  slot_mem_arbiter #(.NUM_CH(4), .ADDR_W(27), .DATA_W(8), .PRIO_CH0(1), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_din(ch_din),
    .ch_ack(ch_ack), .ch_rdata(ch_rdata), .grant(grant), .busy(busy), .timeout_err(timeout_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_req(mem_req),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_dout(mem_dout));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_ch(input int i, input logic we, input logic [26:0] a, input logic [7:0] d);
    ch_we[i] = we;
    ch_addr[i*27 +: 27] = a;
    ch_din[i*8 +: 8] = d;
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ack", ch_ack, 0);
    chk("rst_rdata", ch_rdata, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    // round robin among ch1..ch3 with zero-wait memory
    ch_req = 4'b1110;
    mem_ready = 1'b1;
    mem_done = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("rr_grant", grant, rr_exp[n]);
      chk("rr_mem_req", mem_req, 1);
      step();
      chk("rr_ack", ch_ack, rr_exp[n]);
      if (n == 3) ch_req = 4'b0000;
      step();
      chk("rr_idle_grant", grant, 0);
      chk("rr_idle_busy", busy, 0);
    end
    mem_ready = 1'b0;
    mem_done = 1'b0;
    // single read on ch1, minimum latency
    set_ch(1, 1'b0, 27'h1234, 8'h00);
    ch_req = 4'b0010;
    step();
    chk("rd_mem_req", mem_req, 1);
    chk("rd_grant", grant, 4'b0010);
    chk("rd_busy", busy, 1);
    chk("rd_mem_addr", mem_addr, 27'h1234);
    chk("rd_mem_we", mem_we, 0);
    ch_req = 4'b0000;
    mem_ready = 1'b1;
    mem_done = 1'b1;
    mem_dout = 8'h5A;
    step();
    chk("rd_ack", ch_ack, 4'b0010);
    chk("rd_rdata", ch_rdata, 8'h5A);
    chk("rd_mem_req_drop", mem_req, 0);
    chk("rd_grant_resp", grant, 4'b0010);
    mem_ready = 1'b0;
    mem_done = 1'b0;
    step();
    chk("rd_idle_grant", grant, 0);
    chk("rd_idle_ack", ch_ack, 0);
    // priority: ch2 in WAIT, then ch0 and ch3 request
    ch_req = 4'b0100;
    step();
    chk("pr_grant_ch2", grant, 4'b0100);
    mem_ready = 1'b1;
    step();
    chk("pr_wait_mem_req", mem_req, 0);
    mem_ready = 1'b0;
    ch_req = 4'b1101;
    step();
    chk("pr_wait_no_ack", ch_ack, 0);
    mem_done = 1'b1;
    mem_dout = 8'h77;
    step();
    chk("pr_ack_ch2", ch_ack, 4'b0100);
    chk("pr_rdata_ch2", ch_rdata, 8'h77);
    mem_done = 1'b0;
    ch_req = 4'b1001;
    step();
    step();
    chk("pr_grant_ch0", grant, 4'b0001);
    mem_ready = 1'b1;
    mem_done = 1'b1;
    mem_dout = 8'h11;
    step();
    chk("pr_ack_ch0", ch_ack, 4'b0001);
    ch_req = 4'b1000;
    mem_ready = 1'b0;
    mem_done = 1'b0;
    step();
    step();
    chk("pr_grant_ch3", grant, 4'b1000);
    mem_ready = 1'b1;
    mem_done = 1'b1;
    mem_dout = 8'h33;
    step();
    chk("pr_ack_ch3", ch_ack, 4'b1000);
    chk("pr_rdata_ch3", ch_rdata, 8'h33);
    ch_req = 4'b0000;
    mem_ready = 1'b0;
    mem_done = 1'b0;
    step();
    // stalled write on ch3, inputs changed after grant
    set_ch(3, 1'b1, 27'h7ABCDEF, 8'hC3);
    ch_req = 4'b1000;
    step();
    chk("wr_grant", grant, 4'b1000);
    chk("wr_mem_addr", mem_addr, 27'h7ABCDEF);
    set_ch(3, 1'b0, 27'h0, 8'h00);
    for (int n = 0; n < 3; n++) begin
      chk("wr_mem_din", mem_din, 8'hC3);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_req", mem_req, 1);
      step();
    end
    mem_ready = 1'b1;
    step();
    chk("wr_mem_req_drop", mem_req, 0);
    mem_ready = 1'b0;
    step();
    step();
    chk("wr_no_early_ack", ch_ack, 0);
    mem_done = 1'b1;
    mem_dout = 8'hEE;
    step();
    chk("wr_ack", ch_ack, 4'b1000);
    chk("wr_rdata_held", ch_rdata, 8'h33);
    chk("wr_no_terr", timeout_err, 0);
    mem_done = 1'b0;
    ch_req = 4'b0000;
    step();
    // watchdog abort on ch2, request dropped mid-transaction
    set_ch(2, 1'b0, 27'h42, 8'h00);
    ch_req = 4'b0100;
    mem_ready = 1'b1;
    step();
    chk("to_grant", grant, 4'b0100);
    ch_req = 4'b0000;
    for (int n = 0; n < 7; n++) step();
    chk("to_no_early_ack", ch_ack, 0);
    chk("to_no_early_err", timeout_err, 0);
    step();
    chk("to_ack", ch_ack, 4'b0100);
    chk("to_err", timeout_err, 1);
    chk("to_rdata", ch_rdata, 8'hFF);
    chk("to_mem_req", mem_req, 0);
    step();
    chk("to_err_pulse", timeout_err, 0);
    chk("to_idle_grant", grant, 0);
    // mem_done on the terminal watchdog cycle wins
    ch_req = 4'b0100;
    step();
    chk("tt_grant", grant, 4'b0100);
    ch_req = 4'b0000;
    for (int n = 0; n < 7; n++) step();
    mem_done = 1'b1;
    mem_dout = 8'hA5;
    step();
    chk("tt_ack", ch_ack, 4'b0100);
    chk("tt_no_err", timeout_err, 0);
    chk("tt_rdata", ch_rdata, 8'hA5);
    mem_done = 1'b0;
    step();
    // reset while in WAIT
    ch_req = 4'b0010;
    step();
    step();
    chk("rw_busy_wait", busy, 1);
    chk("rw_mem_req_wait", mem_req, 0);
    ch_req = 4'b0000;
    mem_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_grant", grant, 0);
    chk("rw_busy", busy, 0);
    chk("rw_mem_req", mem_req, 0);
    ack_seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      ack_seen = ack_seen | (|ch_ack) | timeout_err;
    end
    chk("rw_no_ack", ack_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
